// File: rtl/lcd_write_arbiter_if.sv
// Bundles the shared LCD write port: requester handshake plus LCD pins.
// Latency: none, wires only.
// Backpressure: requesters hold req until done; an owner cannot be preempted.
interface lcd_write_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  req_en;
  logic [2:0]  wr_rs;
  logic [23:0] wr_data;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        busy;
  logic [1:0]  owner;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;

  // Display producers: drive requests, observe grant/completion.
  modport master (
    output req, req_en, wr_rs, wr_data,
    input  gnt, done, busy, owner, lcd_en, lcd_rs, lcd_rw, lcd_data
  );

  // Arbiter side: owns the LCD pins and the grant/completion pulses.
  modport slave (
    input  req, req_en, wr_rs, wr_data,
    output gnt, done, busy, owner, lcd_en, lcd_rs, lcd_rw, lcd_data
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one HD44780-style write port among three producers.
// Latency: gnt 1 cycle after request; done SETUP+EN+HOLD+EXEC cycles after gnt.
// Backpressure: a single write in flight; other requests wait until the owner gets done.
module lcd_write_arbiter #(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 12,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000
) (
  input  logic                clk,
  input  logic                rst,
  lcd_write_arbiter_if.slave  bus
);

  localparam int MAX_AB = (SETUP_CYC > EN_CYC)   ? SETUP_CYC : EN_CYC;
  localparam int MAX_CD = (HOLD_CYC  > EXEC_CYC) ? HOLD_CYC  : EXEC_CYC;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [2:0]         done_q, done_d;
  logic               busy_q, busy_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic               en_q, en_d;
  logic               rs_q, rs_d;
  logic [7:0]         dat_q, dat_d;

  logic [2:0]         elig;
  logic [1:0]         c0, c1, c2, pick;

  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // A requester being handed done this cycle must not be re-granted at this edge.
  assign elig = bus.req & bus.req_en & ~done_q;

  // Round-robin pick: scan the three requesters starting after the last winner.
  always_comb begin
    c0 = nxt(last_q);
    c1 = nxt(c0);
    c2 = nxt(c1);
    if (elig[c0])      pick = c0;
    else if (elig[c1]) pick = c1;
    else               pick = c2;
  end

  // Next-state and registered-output logic for the bus timing sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = 3'b000;
    done_d  = 3'b000;
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    en_d    = en_q;
    rs_d    = rs_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          gnt_d   = 3'b001 << pick;
          owner_d = pick;
          busy_d  = 1'b1;
          rs_d    = bus.wr_rs[pick];
          dat_d   = bus.wr_data[{pick, 3'b000} +: 8];
          last_d  = pick;
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(EN_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          en_d    = 1'b0;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = EXEC;
          cnt_d   = CNT_W'(EXEC_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 3'b001 << owner_q;
          owner_d = 2'd3;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'd3;
        busy_d  = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any transfer silently and drops EN at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 3'b000;
      done_q  <= 3'b000;
      busy_q  <= 1'b0;
      owner_q <= 2'd3;
      last_q  <= 2'd2;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;
  assign bus.lcd_en   = en_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_data = dat_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter with short timing parameters.
// Latency: expects gnt 1 cycle after request, done 12 cycles after gnt.
// Backpressure: requests held until grant; one transfer in flight at a time.
module tb_lcd_write_arbiter;

  localparam int S   = 2;
  localparam int E   = 3;
  localparam int H   = 2;
  localparam int X   = 5;
  localparam int TOT = S + E + H + X;

  typedef struct {
    logic [1:0] idx;
    logic       rs;
    logic [7:0] dat;
    logic       gap_chk;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;
  exp_t sb[$];

  lcd_write_arbiter_if bus();

  lcd_write_arbiter #(
    .SETUP_CYC(S),
    .EN_CYC   (E),
    .HOLD_CYC (H),
    .EXEC_CYC (X)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i, input logic gap);
    exp_t e;
    e.idx     = 2'(i);
    e.rs      = bus.wr_rs[i];
    e.dat     = bus.wr_data[8*i +: 8];
    e.gap_chk = gap;
    sb.push_back(e);
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (bus.done == 3'b000 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) chk("done_timeout", 32'(n), 32'd59);
  endtask

  // Monitor: pops the scoreboard on every grant and tracks the transfer timeline.
  logic       active;
  int         g_cyc;
  int         last_g;
  logic [1:0] cur;
  logic       m_rs;
  logic [7:0] m_dat;

  initial begin
    active = 1'b0;
    g_cyc  = 0;
    last_g = 0;
    cur    = 2'd0;
    m_rs   = 1'b0;
    m_dat  = 8'h00;
  end

  always @(negedge clk) begin
    if (!rst) begin
      active = 1'b0;
      m_rs   = 1'b0;
      m_dat  = 8'h00;
    end else begin
      if (bus.gnt != 3'b000) begin
        if (sb.size() == 0) begin
          chk("gnt_unexpected", {29'b0, bus.gnt}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("gnt", {29'b0, bus.gnt}, 32'(3'b001 << e.idx));
          if (e.gap_chk) chk("gnt_gap", 32'(cyc - last_g), 32'(TOT + 1));
          cur    = e.idx;
          m_rs   = e.rs;
          m_dat  = e.dat;
          active = 1'b1;
          g_cyc  = cyc;
          last_g = cyc;
        end
      end
      chk("lcd_rs", {31'b0, bus.lcd_rs}, {31'b0, m_rs});
      chk("lcd_data", {24'b0, bus.lcd_data}, {24'b0, m_dat});
      chk("lcd_rw", {31'b0, bus.lcd_rw}, 32'd0);
      if (active) begin
        int rel;
        rel = cyc - g_cyc;
        chk("lcd_en", {31'b0, bus.lcd_en}, 32'((rel >= S) && (rel < S + E)));
        chk("busy", {31'b0, bus.busy}, 32'(rel < TOT));
        if (rel >= TOT) begin
          chk("done", {29'b0, bus.done}, 32'(3'b001 << cur));
          chk("owner_idle", {30'b0, bus.owner}, 32'd3);
          active = 1'b0;
        end else begin
          chk("done_early", {29'b0, bus.done}, 32'd0);
          chk("owner", {30'b0, bus.owner}, {30'b0, cur});
        end
      end else begin
        chk("idle_busy", {31'b0, bus.busy}, 32'd0);
        chk("idle_done", {29'b0, bus.done}, 32'd0);
        chk("idle_en", {31'b0, bus.lcd_en}, 32'd0);
        chk("idle_owner", {30'b0, bus.owner}, 32'd3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst         = 1'b0;
    bus.req     = 3'b000;
    bus.req_en  = 3'b111;
    bus.wr_rs   = 3'b101;
    bus.wr_data = {8'h7C, 8'h62, 8'h41};
    repeat (3) tick();

    // Reset values.
    chk("rst_gnt", {29'b0, bus.gnt}, 32'd0);
    chk("rst_done", {29'b0, bus.done}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_owner", {30'b0, bus.owner}, 32'd3);
    chk("rst_en", {31'b0, bus.lcd_en}, 32'd0);
    chk("rst_data", {24'b0, bus.lcd_data}, 32'd0);
    rst = 1'b1;
    tick();

    // Single write from requester 0: RS=1, data 0x41.
    push_exp(0, 1'b0);
    bus.req = 3'b001;
    tick();
    bus.req = 3'b000;
    wait_done();
    tick();
    repeat (2) tick();

    // Masking: requester 0 masked while requesting; 1 wins, then 0 after unmask.
    bus.wr_rs   = 3'b010;
    bus.wr_data = {8'h7C, 8'hA5, 8'h0F};
    bus.req_en  = 3'b110;
    push_exp(1, 1'b0);
    bus.req = 3'b011;
    tick();
    bus.req = 3'b001;
    wait_done();
    tick();
    repeat (5) tick();
    push_exp(0, 1'b0);
    bus.req_en = 3'b111;
    tick();
    bus.req = 3'b000;
    wait_done();
    tick();
    repeat (2) tick();

    // Done exclusion: requester 0 keeps req one cycle past done.
    bus.wr_data = {8'h7C, 8'hA5, 8'h3C};
    push_exp(0, 1'b0);
    bus.req = 3'b001;
    tick();
    wait_done();
    tick();
    chk("excl_gnt", {29'b0, bus.gnt}, 32'd0);
    chk("excl_busy", {31'b0, bus.busy}, 32'd0);
    bus.req = 3'b000;
    repeat (3) tick();

    // Withdrawal: requester 2 raises and drops req while 0 owns the bus.
    bus.wr_data = {8'h7C, 8'hA5, 8'h5A};
    push_exp(0, 1'b0);
    bus.req = 3'b001;
    tick();
    bus.req = 3'b000;
    repeat (2) tick();
    bus.req = 3'b100;
    repeat (3) tick();
    bus.req = 3'b000;
    wait_done();
    tick();
    repeat (4) tick();
    chk("wd_busy", {31'b0, bus.busy}, 32'd0);

    // Reset mid-pulse, then round-robin from reset priority.
    bus.wr_data = {8'h7C, 8'h62, 8'hC3};
    bus.wr_rs   = 3'b011;
    push_exp(0, 1'b0);
    bus.req = 3'b001;
    tick();
    bus.req = 3'b000;
    repeat (3) tick();
    chk("pre_rst_en", {31'b0, bus.lcd_en}, 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_rst_en", {31'b0, bus.lcd_en}, 32'd0);
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_owner", {30'b0, bus.owner}, 32'd3);
    chk("mid_rst_data", {24'b0, bus.lcd_data}, 32'd0);
    chk("mid_rst_rs", {31'b0, bus.lcd_rs}, 32'd0);
    chk("mid_rst_done", {29'b0, bus.done}, 32'd0);
    rst = 1'b1;
    repeat (12) tick();

    push_exp(0, 1'b0);
    push_exp(1, 1'b1);
    push_exp(2, 1'b1);
    push_exp(0, 1'b1);
    bus.req = 3'b111;
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_done();
      tick();
      if (i == 2) bus.req = 3'b000;
    end
    repeat (4) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
